// File: rtl/fp32_mul_iter_pkg.sv
// Shared FP32 constants, FSM states and decoded-field bundle
// for the iterative FP32 multiplier.
package fp32_mul_iter_pkg;

  localparam int FP32_BIAS    = 127;
  localparam int FP32_EXP_MAX = 255;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_INF  = 32'h7F800000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
    logic        is_snan;
  } fp32_dec_t;

endpackage

// File: rtl/Fp32Decoder.sv
// Splits a binary32 word into fields and class flags.
// Denormals are reported as zero (flush-to-zero).
module Fp32Decoder
  import fp32_mul_iter_pkg::*;
(
  input  logic [31:0] op_i,
  output fp32_dec_t   dec_o
);

  logic exp_zero;
  logic exp_ones;
  logic man_zero;

  // Field split and operand classification.
  always_comb begin
    exp_zero      = (op_i[30:23] == 8'h00);
    exp_ones      = (op_i[30:23] == 8'hFF);
    man_zero      = (op_i[22:0] == 23'h0);
    dec_o.sign    = op_i[31];
    dec_o.expo    = op_i[30:23];
    dec_o.mant    = op_i[22:0];
    dec_o.is_zero = exp_zero;
    dec_o.is_inf  = exp_ones & man_zero;
    dec_o.is_nan  = exp_ones & ~man_zero;
    dec_o.is_snan = exp_ones & ~man_zero
                  & ~op_i[22];
  end

endmodule

// File: rtl/fp32_mul_iter.sv
// Iterative shift-and-add FP32 multiplier, RNE rounding,
// flush-to-zero, one operation in flight.
module fp32_mul_iter
  import fp32_mul_iter_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_nv,
  output logic        flag_of,
  output logic        flag_uf
);

  localparam int BPC  = BITS_PER_CYCLE;
  localparam int NCYC = 24 / BPC;

  localparam logic signed [9:0] EXP_MAX_S =
    10'(FP32_EXP_MAX);

  if (!(BPC == 1 || BPC == 2 || BPC == 3 ||
        BPC == 4 || BPC == 6 || BPC == 8))
  begin : g_bad_bpc
    $error("BITS_PER_CYCLE must divide 24");
  end

  fp32_dec_t da;
  fp32_dec_t db;

  Fp32Decoder u_dec_a (
    .op_i  (a),
    .dec_o (da)
  );

  Fp32Decoder u_dec_b (
    .op_i  (b),
    .dec_o (db)
  );

  state_e             state_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [47:0]        acc_q;
  logic [47:0]        mcand_q;
  logic [23:0]        mplr_q;
  logic [4:0]         cnt_q;
  logic               out_valid_q;
  logic [31:0]        result_q;
  logic               nv_q;
  logic               of_q;
  logic               uf_q;

  logic               sign_d;
  logic               spc;
  logic [31:0]        spc_res;
  logic               spc_nv;
  logic [47:0]        acc_d;
  logic               p_hi;
  logic [22:0]        keep;
  logic               grd;
  logic               stk;
  logic               rnd;
  logic [23:0]        mant_r;
  logic signed [9:0]  exp_n;
  logic               norm_of;
  logic               norm_uf;
  logic [31:0]        norm_res;

  assign in_ready  = (state_q == IDLE) & ~reset;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_nv   = nv_q;
  assign flag_of   = of_q;
  assign flag_uf   = uf_q;

  // Special-operand results resolved straight from the decoders.
  always_comb begin
    sign_d  = da.sign ^ db.sign;
    spc     = 1'b0;
    spc_res = 32'h0;
    spc_nv  = 1'b0;
    if (da.is_nan | db.is_nan) begin
      spc     = 1'b1;
      spc_res = FP32_QNAN;
      spc_nv  = da.is_snan | db.is_snan;
    end else if ((da.is_inf & db.is_zero) |
                 (da.is_zero & db.is_inf)) begin
      spc     = 1'b1;
      spc_res = FP32_QNAN;
      spc_nv  = 1'b1;
    end else if (da.is_inf | db.is_inf) begin
      spc     = 1'b1;
      spc_res = FP32_INF | {sign_d, 31'h0};
    end else if (da.is_zero | db.is_zero) begin
      spc     = 1'b1;
      spc_res = {sign_d, 31'h0};
    end
  end

  // One MUL step: retire BPC multiplier bits into the accumulator.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < BPC; i++) begin
      if (mplr_q[i]) begin
        acc_d = acc_d + (mcand_q << i);
      end
    end
  end

  // Normalise, round to nearest even and pack the product.
  always_comb begin
    p_hi = acc_q[47];
    if (p_hi) begin
      keep = acc_q[46:24];
      grd  = acc_q[23];
      stk  = |acc_q[22:0];
    end else begin
      keep = acc_q[45:23];
      grd  = acc_q[22];
      stk  = |acc_q[21:0];
    end
    rnd     = grd & (stk | keep[0]);
    mant_r  = {1'b0, keep} + {23'h0, rnd};
    exp_n   = exp_q + 10'(p_hi) + 10'(mant_r[23]);
    norm_of = (exp_n >= EXP_MAX_S);
    norm_uf = (exp_n <= 10'sd0);
    if (norm_of) begin
      norm_res = FP32_INF | {sign_q, 31'h0};
    end else if (norm_uf) begin
      norm_res = {sign_q, 31'h0};
    end else begin
      norm_res = {sign_q, exp_n[7:0], mant_r[22:0]};
    end
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      nv_q        <= 1'b0;
      of_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q  <= sign_d;
            exp_q   <= 10'({2'b0, da.expo}
                     + {2'b0, db.expo}
                     - 10'(FP32_BIAS));
            acc_q   <= '0;
            mcand_q <= {24'h0, 1'b1, da.mant};
            mplr_q  <= {1'b1, db.mant};
            cnt_q   <= 5'(NCYC - 1);
            if (spc) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= spc_res;
              nv_q        <= spc_nv;
              of_q        <= 1'b0;
              uf_q        <= 1'b0;
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << BPC;
          mplr_q  <= mplr_q >> BPC;
          if (cnt_q == 5'd0) begin
            state_q <= NORM;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        NORM: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          result_q    <= norm_res;
          nv_q        <= 1'b0;
          of_q        <= norm_of;
          uf_q        <= norm_uf;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_iter.sv
// Self-checking bench for fp32_mul_iter: directed cases from the
// test plan plus random operands against an arithmetic model.
module tb_fp32_mul_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_ready = 1'b1;

  logic        in_valid0 = 1'b0;
  logic        in_ready0;
  logic        out_valid0;
  logic [31:0] result0;
  logic        nv0, of0, uf0;

  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic        out_valid1;
  logic [31:0] result1;
  logic        nv1, of1, uf1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fp32_mul_iter #(.BITS_PER_CYCLE(1)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .a         (a),
    .b         (b),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .result    (result0),
    .flag_nv   (nv0),
    .flag_of   (of0),
    .flag_uf   (uf0)
  );

  fp32_mul_iter #(.BITS_PER_CYCLE(4)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .result    (result1),
    .flag_nv   (nv1),
    .flag_of   (of1),
    .flag_uf   (uf1)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic ov(input int d);
    return (d == 0) ? out_valid0 : out_valid1;
  endfunction

  function automatic logic [31:0] res(input int d);
    return (d == 0) ? result0 : result1;
  endfunction

  function automatic logic [2:0] flg(input int d);
    return (d == 0) ? {nv0, of0, uf0} : {nv1, of1, uf1};
  endfunction

  // Reference: {special, nv, of, uf, result}, from IEEE rules
  // with exact integer product and RNE on the remainder.
  function automatic logic [35:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    logic s;
    int ex, ey, e, sh;
    logic nx, ny, snx, sny, ix, iy, zx, zy;
    longint one, p, q, rem, half;
    one = 1;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    snx = nx && !x[22];
    sny = ny && !y[22];
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    if (nx || ny) return {1'b1, snx | sny, 2'b00, 32'h7FC00000};
    if ((ix && zy) || (zx && iy))
      return {1'b1, 3'b100, 32'h7FC00000};
    if (ix || iy) return {1'b1, 3'b000, s, 31'h7F800000};
    if (zx || zy) return {1'b1, 3'b000, s, 31'h0};
    p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
    e = ex + ey - 127;
    if (p >= (one << 47)) begin
      sh = 24;
      e++;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = one << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (one << 24)) begin
      q = one << 23;
      e++;
    end
    if (e >= 255) return {1'b0, 3'b010, s, 31'h7F800000};
    if (e <= 0) return {1'b0, 3'b001, s, 31'h0};
    return {1'b0, 3'b000, s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic s;
    int k;
    logic [22:0] m;
    s = 1'($urandom);
    k = $urandom_range(0, 15);
    m = 23'($urandom);
    if (k == 15) m = m & 23'h7F0000;
    case (k)
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 1'b1, m[21:0]};
      3: return {s, 8'hFF, 1'b0, m[21:0] | 22'h1};
      4: return {s, 8'h00, m | 23'h1};
      5, 6: return {s, 8'($urandom_range(1, 254)), m};
      default: return {s, 8'($urandom_range(100, 154)), m};
    endcase
  endfunction

  // Issue one operation; entered and left #1 after a posedge.
  task automatic op(input int d,
                    input logic [31:0] x,
                    input logic [31:0] y,
                    output logic [31:0] r,
                    output logic [2:0] f,
                    output int lat);
    a = x;
    b = y;
    if (d == 0) in_valid0 = 1'b1;
    else in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    lat = 1;
    while (!ov(d) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = res(d);
    f = flg(d);
  endtask

  task automatic run(input int d,
                     input string tag,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] er,
                     input logic [2:0] ef,
                     input int el);
    logic [31:0] r;
    logic [2:0] f;
    int lat;
    op(d, x, y, r, f, lat);
    chk({tag, " result"}, r, er);
    chk({tag, " flags"}, {29'h0, f}, {29'h0, ef});
    chk({tag, " latency"}, 32'(lat), 32'(el));
    @(posedge clk);
    #1;
  endtask

  task automatic run_rand(input int d, input int n);
    logic [31:0] x, y;
    logic [35:0] m;
    int el;
    for (int i = 0; i < n; i++) begin
      x = rnd_op();
      y = rnd_op();
      m = ref_mul(x, y);
      el = m[35] ? 1 : ((d == 0) ? 26 : 8);
      run(d, $sformatf("rand%0d_%0d", d, i), x, y,
          m[31:0], m[34:32], el);
    end
  endtask

  logic [31:0] hold_r;
  logic [2:0]  hold_f;
  int          hold_l;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("in_ready during reset", 32'(in_ready0), 32'd0);
    reset = 1'b0;
    #1;
    chk("reset out_valid", 32'(out_valid0), 32'd0);
    chk("reset result", result0, 32'h0);
    chk("reset flags", {29'h0, flg(0)}, 32'h0);
    chk("reset in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk);
    #1;

    run(0, "1.5x2", 32'h3FC00000, 32'h40000000,
        32'h40400000, 3'b000, 26);
    run(0, "tie_odd", 32'h3F800001, 32'h3FC00000,
        32'h3FC00002, 3'b000, 26);
    run(0, "below_half", 32'h3F800001, 32'h3F800001,
        32'h3F800002, 3'b000, 26);
    run(0, "inf_x_zero", 32'h7F800000, 32'h00000000,
        32'h7FC00000, 3'b100, 1);
    run(0, "ninf_x_2", 32'hFF800000, 32'h40000000,
        32'hFF800000, 3'b000, 1);
    run(0, "overflow", 32'h7F000000, 32'h7F000000,
        32'h7F800000, 3'b010, 26);
    run(0, "underflow", 32'h00800000, 32'h00800000,
        32'h00000000, 3'b001, 26);
    run(0, "denorm", 32'h00000001, 32'h40000000,
        32'h00000000, 3'b000, 1);
    run(0, "snan", 32'h7F800001, 32'h3F800000,
        32'h7FC00000, 3'b100, 1);
    run(0, "qnan", 32'h7FC00001, 32'h3F800000,
        32'h7FC00000, 3'b000, 1);

    out_ready = 1'b0;
    op(0, 32'h3FC00000, 32'h40000000, hold_r, hold_f, hold_l);
    chk("bp result", hold_r, 32'h40400000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d result", i), result0, hold_r);
      chk($sformatf("bp%0d flags", i), {29'h0, flg(0)},
          {29'h0, hold_f});
      chk($sformatf("bp%0d out_valid", i), 32'(out_valid0), 32'd1);
      chk($sformatf("bp%0d in_ready", i), 32'(in_ready0), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release out_valid", 32'(out_valid0), 32'd0);
    chk("bp release in_ready", 32'(in_ready0), 32'd1);
    run(0, "after_bp", 32'hC0000000, 32'h3FC00000,
        32'hC0400000, 3'b000, 26);

    a = 32'h3FC00000;
    b = 32'h40000000;
    in_valid0 = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid-MUL in_ready", 32'(in_ready0), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mul out_valid", 32'(out_valid0), 32'd0);
    chk("rst_mul result", result0, 32'h0);
    chk("rst_mul in_ready", 32'(in_ready0), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("rst_mul discarded", 32'(out_valid0), 32'd0);

    run(1, "bpc4 1.5x2", 32'h3FC00000, 32'h40000000,
        32'h40400000, 3'b000, 8);
    run(1, "bpc4 tie_odd", 32'h3F800001, 32'h3FC00000,
        32'h3FC00002, 3'b000, 8);

    run_rand(0, 40);
    run_rand(1, 30);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp32_mul_iter.md
Name: fp32_mul_iter

Overview:
- Iterative, multi-cycle FP32 multiplier.
- Sits directly downstream of the FP32 field decoder: consumes sign/exponent/mantissa and the class flags for both operands, and produces a packed IEEE-754 binary32 product.
- Used by the FPU datapath where area matters more than throughput. Valid/ready on both sides; one operation in flight.

Parameters:
- BITS_PER_CYCLE, default 1: multiplier bits retired per MUL cycle. Legal values are 1, 2, 3, 4, 6, 8 (must divide 24); any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept; equals (state==IDLE) & !reset
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- out_valid  output  1  result valid; registered
- out_ready  input  1  consumer accepts result
- result  output  32  product, binary32; registered
- flag_nv  output  1  invalid operation; registered
- flag_of  output  1  overflow to infinity; registered
- flag_uf  output  1  result flushed to zero by underflow; registered

Behaviour:
- Reset: state=IDLE, out_valid=0, result=0, flags=0, counter=0. Reset wins over every other event in the same cycle, including an operation mid-MUL or a held DONE; that operation is discarded.
- States: IDLE, MUL, NORM, DONE.
- IDLE: on in_valid & in_ready (cycle T):
  - Latch the decoded fields of a and b. sign = sa^sb.
  - Load 48-bit accumulator=0.
  - Load multiplier=1.m_b and multiplicand=1.m_a, with the hidden bit set.
  - Compute exp_sum = ea + eb - 127 as 10-bit signed.
- Special-case path: from IDLE go directly to DONE; out_valid is high at T+1.
  - Any NaN input -> result 0x7FC00000. flag_nv=1 if any input is signalling (mantissa[22]==0).
  - inf*zero (either order) -> 0x7FC00000, flag_nv=1.
  - inf * finite-or-inf -> sign|0x7F800000.
  - zero * anything else -> sign|0x00000000.
  - Denormal inputs: flush-to-zero, treated as zero with sign kept. No flag.
- MUL: each cycle add (multiplicand << i) for each set multiplier bit among BITS_PER_CYCLE LSBs, then shift the multiplier right. Runs 24/BITS_PER_CYCLE cycles, down-counter to 0, then go to NORM.
- NORM (single cycle), product p[47:0]:
  - If p[47]: keep p[46:24], guard = p[23], sticky = |p[22:0], exp = exp_sum+1.
  - Else: keep p[45:23], guard = p[22], sticky = |p[21:0], exp = exp_sum.
  - Round to nearest, ties to even: increment when guard & (sticky | lsb).
  - If the mantissa carries out, mantissa=0 and exp+1.
  - exp >= 255 -> sign|0x7F800000, flag_of=1.
  - exp <= 0 -> sign|0 (FTZ), flag_uf=1.
  - Otherwise pack {sign, exp[7:0], mant}. Go to DONE.
- DONE: out_valid=1. result and flags are stable while out_ready=0. On out_ready, go to IDLE next cycle and clear out_valid.
- Latency on the normal path: out_valid at T + 24/BITS_PER_CYCLE + 2 (26 at default).
- Throughput: in_ready is low outside IDLE, so there is no accept in the same cycle as a result handshake. Minimum issue interval is latency+1.
- in_valid while busy is ignored; the upstream stage must hold its operands.

Decomposition:
- Shared fp32 package holds:
  - constants FP32_BIAS=127, FP32_EXP_MAX=255, FP32_QNAN=32'h7FC00000, FP32_INF=32'h7F800000
  - state enum {IDLE, MUL, NORM, DONE}
- Sub-module: two instances of Fp32Decoder, one per operand. Its class outputs drive the special-case path.
- Rounding/packing stays inline in NORM; no separate module.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0), BITS_PER_CYCLE=1, out_ready=1 -> result 0x40400000, no flags, out_valid exactly 26 cycles after accept.
- 0x3F800001 * 0x3FC00000 (exact tie, odd lsb) -> 0x3FC00002. 0x3F800001 * 0x3F800001 (below half) -> 0x3F800002.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, flag_nv=1, out_valid at T+1. 0xFF800000 * 0x40000000 -> 0xFF800000, no flags.
- 0x7F000000 * 0x7F000000 -> 0x7F800000, flag_of=1. 0x00800000 * 0x00800000 -> 0x00000000, flag_uf=1. 0x00000001 * 0x40000000 -> 0x00000000, no flags.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0. Release -> IDLE next cycle, next op accepted the cycle after.
- Assert reset for 1 cycle during MUL -> out_valid=0, result=0, in_ready=1 the cycle after reset deasserts. Repeat the first scenario with BITS_PER_CYCLE=4 -> same result, latency 8.
